// File: rtl/cordic_angle_sequencer.sv
// Angle-constant sequencer for the iterative CORDIC core: streams one registered
// (step, shift, angle) descriptor per handshake, circular or hyperbolic.
module cordic_angle_sequencer #(
  parameter int N = 32,
  parameter int I = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   abort,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [$clog2(I)-1:0]   out_step,
  output logic [$clog2(I+1)-1:0] out_shift,
  output logic [N-1:0]           out_angle,
  output logic                   out_last,
  output logic                   busy
);

  localparam int SW = $clog2(I);
  localparam int KW = $clog2(I+1);
  localparam int DROP = 32 - N;
  localparam logic [31:0] PI_4 = 32'h1921FB54;

  typedef logic [29:0][N-1:0] tbl_t;

  // Tables are built at elaboration from the atan/artanh power series in Q4.60,
  // then rounded to Q3.29 and narrowed; atan(1) is seeded since its series crawls.
  function automatic tbl_t build_tbl(input logic hyp);
    tbl_t   t;
    longint acc;
    longint term;
    longint master;
    int     k;
    int     sh;
    for (int e = 0; e < 30; e++) begin
      k   = hyp ? e + 1 : e;
      acc = 0;
      for (int n = 0; n < 32; n++) begin
        sh = 60 - k * (2 * n + 1);
        if (k > 0 && sh >= 0) begin
          term = (64'sd1 << sh) / longint'(2 * n + 1);
          if (hyp || (n % 2 == 0)) acc = acc + term;
          else                     acc = acc - term;
        end
      end
      master = (!hyp && k == 0) ? longint'(PI_4) : ((acc + (64'sd1 << 30)) >>> 31);
      if (DROP == 0) t[e] = N'(master);
      else t[e] = N'((master + (64'sd1 << (DROP > 0 ? DROP - 1 : 0))) >>> DROP);
    end
    return t;
  endfunction

  localparam tbl_t CIRC = build_tbl(1'b0);
  localparam tbl_t HYP  = build_tbl(1'b1);

  function automatic logic [N-1:0] lut(input logic hyp, input logic [KW-1:0] k);
    logic [4:0] idx;
    idx = hyp ? (5'(k) - 5'd1) : 5'(k);
    return hyp ? HYP[idx] : CIRC[idx];
  endfunction

  // state | meaning
  // IDLE  | no run; out_valid=0, busy=0; waits for start (abort has priority)
  // RUN   | descriptor presented; advances on out_ready, leaves after last or abort
  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic            mode_q;
  logic            rep;
  logic            hold_k;
  logic [SW-1:0]   step_nx;
  logic [KW-1:0]   shift_nx;

  // Hyperbolic convergence needs shifts 4 and 13 issued twice.
  always_comb begin
    hold_k   = mode_q && !rep && (int'(out_shift) == 4 || int'(out_shift) == 13);
    step_nx  = out_step + SW'(1);
    shift_nx = hold_k ? out_shift : out_shift + KW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      rep       <= 1'b0;
      out_valid <= 1'b0;
      out_step  <= '0;
      out_shift <= '0;
      out_angle <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= RUN;
            mode_q    <= mode;
            rep       <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_step  <= '0;
            out_shift <= mode ? KW'(1) : '0;
            out_angle <= mode ? HYP[0] : CIRC[0];
            out_last  <= 1'b0;
          end
        end
        RUN: begin
          if (abort || (out_ready && out_last)) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_last  <= 1'b0;
          end else if (out_ready) begin
            out_step  <= step_nx;
            out_shift <= shift_nx;
            rep       <= hold_k;
            out_angle <= lut(mode_q, shift_nx);
            out_last  <= (step_nx == SW'(I - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
